// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types for the pipeline hazard controller
package hazard_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int N_TRK  = 3;
  localparam int TRK_EX = 0;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             reg_write;
    logic             mem_to_reg;
  } hazard_entry_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  localparam hazard_entry_t ENTRY_EMPTY = '0;

  function automatic hazard_entry_t make_entry(input logic [REG_W-1:0] dst,
                                               input logic reg_write,
                                               input logic mem_to_reg);
    hazard_entry_t e;
    e.valid      = 1'b1;
    e.dst        = dst;
    e.reg_write  = reg_write;
    e.mem_to_reg = mem_to_reg;
    return e;
  endfunction

  // The producer closest to execute holds the newest value, so it wins.
  function automatic fwd_sel_t pick_fwd(input logic hit_ex, input logic hit_mem);
    if (hit_ex)  return FWD_MEM;
    if (hit_mem) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - compares one tracked entry against one decode source register
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  hazard_entry_t    entry_i,
  input  logic [REG_W-1:0] src_i,
  input  logic             used_i,
  output logic             hit_o,
  output logic             load_hit_o
);

  // Register 0 is hardwired to zero and never produces a dependency.
  assign hit_o = used_i & entry_i.valid & entry_i.reg_write &
                 (entry_i.dst != '0) & (entry_i.dst == src_i);

  assign load_hit_o = hit_o & entry_i.mem_to_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW hazard detection, stall/bubble control and operand forwarding
// Optional feature: define HAZARD_FORWARD_EN to enable execute-stage forwarding.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REG_W-1:0]       id_rs,
  input  logic [REG_W-1:0]       id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [REG_W-1:0]       id_dst,
  input  logic                   id_reg_write,
  input  logic                   id_mem_to_reg,
  input  logic                   mem_busy,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   flush_e,
  output logic                   hold_e,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  hazard_entry_t ex_q, ex_d;
  hazard_entry_t mem_q, mem_d;
  hazard_entry_t wb_q, wb_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  hazard_entry_t [N_TRK-1:0] trk;
  logic [N_TRK-1:0] hit_rs, hit_rt, ld_rs, ld_rt;
  logic use_rs, use_rt;
  logic frozen, hazard, bubble;

  assign trk    = {wb_q, mem_q, ex_q};
  assign use_rs = id_valid & id_uses_rs;
  assign use_rt = id_valid & id_uses_rt;
  assign frozen = mem_busy;
  assign bubble = hazard | ~id_valid;

  for (genvar i = 0; i < N_TRK; i++) begin : g_trk
    hazard_match u_rs (
      .entry_i   (trk[i]),
      .src_i     (id_rs),
      .used_i    (use_rs),
      .hit_o     (hit_rs[i]),
      .load_hit_o(ld_rs[i])
    );
    hazard_match u_rt (
      .entry_i   (trk[i]),
      .src_i     (id_rt),
      .used_i    (use_rt),
      .hit_o     (hit_rt[i]),
      .load_hit_o(ld_rt[i])
    );
  end

`ifdef HAZARD_FORWARD_EN
  // Only a load in execute cannot be forwarded in time; everything else bypasses.
  assign hazard = ld_rs[TRK_EX] | ld_rt[TRK_EX];

  logic unused_trk;
  assign unused_trk = ^{hit_rs[2], hit_rt[2], ld_rs[2:1], ld_rt[2:1]};
`else
  // No write-through: wait until the producer has left writeback.
  assign hazard = |{hit_rs, hit_rt};

  logic unused_trk;
  assign unused_trk = ^{ld_rs, ld_rt};
`endif

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_e = 1'b0;
    hold_e  = 1'b0;
    if (frozen) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      hold_e  = 1'b1;
    end else if (hazard) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!frozen) begin
      ex_d  = bubble ? ENTRY_EMPTY : make_entry(id_dst, id_reg_write, id_mem_to_reg);
      mem_d = ex_q;
      wb_d  = mem_q;
      if (hazard && (cnt_q != '1)) begin
        cnt_d = cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= ENTRY_EMPTY;
      mem_q <= ENTRY_EMPTY;
      wb_q  <= ENTRY_EMPTY;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

`ifdef HAZARD_FORWARD_EN
  fwd_sel_t fwd_a_q, fwd_a_d;
  fwd_sel_t fwd_b_q, fwd_b_d;

  // Selects are resolved against today's ex/mem, which become tomorrow's mem/wb.
  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!frozen) begin
      if (bubble) begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
      end else begin
        fwd_a_d = pick_fwd(hit_rs[0], hit_rs[1]);
        fwd_b_d = pick_fwd(hit_rt[0], hit_rt[1]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

  logic unused_ld;
  assign unused_ld = ^{mem_q.mem_to_reg, wb_q.mem_to_reg};
`else
  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;

  logic unused_ld;
  assign unused_ld = ^{ex_q.mem_to_reg, mem_q.mem_to_reg, wb_q.mem_to_reg};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven bench for hazard_ctrl (both HAZARD_FORWARD_EN builds)
module tb_hazard_ctrl;

  typedef struct {
    logic       val;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       rw;
    logic       ld;
    logic       busy;
    logic [3:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    int         cnt;
  } vec_t;

  localparam logic [3:0] N = 4'b0000;
  localparam logic [3:0] S = 4'b1110;
  localparam logic [3:0] F = 4'b1101;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_to_reg, mem_busy;
  logic [4:0] id_rs, id_rt, id_dst;
  logic stall_f, stall_d, flush_e, hold_e;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cnt;
  logic s_stall_f, s_stall_d, s_flush_e, s_hold_e;
  logic [1:0] s_fwd_a_sel, s_fwd_b_sel;
  logic [1:0] s_stall_cnt;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.STALL_CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .mem_busy(mem_busy),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e), .hold_e(hold_e),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.STALL_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .mem_busy(mem_busy),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_e(s_flush_e), .hold_e(s_hold_e),
    .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel), .stall_cnt(s_stall_cnt)
  );

  function automatic vec_t v(input bit val, input int rs, input int rt, input bit urs,
                             input bit urt, input int dst, input bit rw, input bit ld,
                             input bit busy, input logic [3:0] ctl, input int fa,
                             input int fb, input int cnt);
    vec_t r;
    r.val = val;  r.rs = 5'(rs);  r.rt = 5'(rt);  r.urs = urs;  r.urt = urt;
    r.dst = 5'(dst);  r.rw = rw;  r.ld = ld;  r.busy = busy;
    r.ctl = ctl;  r.fa = 2'(fa);  r.fb = 2'(fb);  r.cnt = cnt;
    return r;
  endfunction

  function automatic vec_t nop(input int fa, input int fb, input int cnt);
    return v(0, 0, 0, 0, 0, 0, 0, 0, 0, N, fa, fb, cnt);
  endfunction

  task automatic chk(input string nm, input int row, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    id_valid = r.val;  id_rs = r.rs;  id_rt = r.rt;
    id_uses_rs = r.urs;  id_uses_rt = r.urt;  id_dst = r.dst;
    id_reg_write = r.rw;  id_mem_to_reg = r.ld;  mem_busy = r.busy;
  endtask

  task automatic check_all(input int row, input logic [3:0] ctl, input logic [1:0] fa,
                           input logic [1:0] fb, input int cnt);
    int sat;
    sat = (cnt > 3) ? 3 : cnt;
    chk("stall_f", row, stall_f, ctl[3]);
    chk("stall_d", row, stall_d, ctl[2]);
    chk("flush_e", row, flush_e, ctl[1]);
    chk("hold_e", row, hold_e, ctl[0]);
    chk("fwd_a_sel", row, fwd_a_sel, fa);
    chk("fwd_b_sel", row, fwd_b_sel, fb);
    chk("stall_cnt", row, stall_cnt, cnt);
    chk("sat_cnt", row, s_stall_cnt, sat);
    chk("sat_ctl", row, {s_stall_f, s_stall_d, s_flush_e, s_hold_e, s_fwd_a_sel, s_fwd_b_sel},
        {ctl, fa, fb});
  endtask

  initial begin
`ifdef HAZARD_FORWARD_EN
    tbl.push_back(v(1,1,2,1,1,3,1,0,0,N,0,0,0));
    tbl.push_back(v(1,3,5,1,1,4,1,0,0,N,0,0,0));
    tbl.push_back(nop(1,0,0));
    tbl.push_back(nop(0,0,0));
    tbl.push_back(nop(0,0,0));
    tbl.push_back(v(1,1,2,1,1,0,1,0,0,N,0,0,0));
    tbl.push_back(v(1,0,0,1,1,5,1,0,0,N,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(nop(0,0,0));
    tbl.push_back(v(1,1,0,1,0,3,1,1,0,N,0,0,0));
    tbl.push_back(v(1,5,3,1,1,4,1,0,0,S,0,0,0));
    tbl.push_back(v(1,5,3,1,1,4,1,0,0,N,0,0,1));
    tbl.push_back(nop(0,2,1));
    tbl.push_back(nop(0,0,1));
    tbl.push_back(nop(0,0,1));
    tbl.push_back(v(1,1,0,1,0,3,1,1,0,N,0,0,1));
    for (int i = 0; i < 3; i++) tbl.push_back(v(1,5,3,1,1,4,1,0,1,F,0,0,1));
    tbl.push_back(v(1,5,3,1,1,4,1,0,0,S,0,0,1));
    tbl.push_back(v(1,5,3,1,1,4,1,0,0,N,0,0,2));
    tbl.push_back(nop(0,2,2));
    tbl.push_back(nop(0,0,2));
    tbl.push_back(nop(0,0,2));
    tbl.push_back(v(1,1,2,1,1,3,1,0,0,N,0,0,2));
    tbl.push_back(v(1,1,1,1,1,3,1,0,0,N,0,0,2));
    tbl.push_back(v(1,3,3,1,1,4,1,0,0,N,0,0,2));
    tbl.push_back(nop(1,1,2));
    tbl.push_back(nop(0,0,2));
    tbl.push_back(v(1,1,2,1,1,3,1,0,0,N,0,0,2));
    tbl.push_back(nop(0,0,2));
    tbl.push_back(v(1,3,0,1,0,4,1,0,0,N,0,0,2));
    tbl.push_back(nop(2,0,2));
    tbl.push_back(nop(0,0,2));
    tbl.push_back(v(1,1,0,1,0,3,1,1,0,N,0,0,2));
    tbl.push_back(v(1,3,0,1,0,5,1,0,0,S,0,0,2));
    tbl.push_back(v(1,3,0,1,0,6,1,1,0,N,0,0,3));
    tbl.push_back(v(1,6,0,1,0,7,1,0,0,S,2,0,3));
    tbl.push_back(v(1,6,0,1,0,7,1,0,0,N,0,0,4));
    tbl.push_back(nop(2,0,4));
    tbl.push_back(nop(0,0,4));
    tbl.push_back(nop(0,0,4));
`else
    tbl.push_back(v(1,1,2,1,1,3,1,0,0,N,0,0,0));
    tbl.push_back(v(1,3,5,1,1,4,1,0,0,S,0,0,0));
    tbl.push_back(v(1,3,5,1,1,4,1,0,0,S,0,0,1));
    tbl.push_back(v(1,3,5,1,1,4,1,0,0,S,0,0,2));
    tbl.push_back(v(1,3,5,1,1,4,1,0,0,N,0,0,3));
    for (int i = 0; i < 3; i++) tbl.push_back(nop(0,0,3));
    tbl.push_back(v(1,1,2,1,1,0,1,0,0,N,0,0,3));
    tbl.push_back(v(1,0,0,1,1,5,1,0,0,N,0,0,3));
    for (int i = 0; i < 3; i++) tbl.push_back(nop(0,0,3));
    tbl.push_back(v(1,1,0,1,0,3,1,1,0,N,0,0,3));
    tbl.push_back(v(1,5,3,1,1,4,1,0,0,S,0,0,3));
    tbl.push_back(v(1,5,3,1,1,4,1,0,0,S,0,0,4));
    tbl.push_back(v(1,5,3,1,1,4,1,0,0,S,0,0,5));
    tbl.push_back(v(1,5,3,1,1,4,1,0,0,N,0,0,6));
    for (int i = 0; i < 3; i++) tbl.push_back(nop(0,0,6));
    tbl.push_back(v(1,1,0,1,0,3,1,1,0,N,0,0,6));
    for (int i = 0; i < 3; i++) tbl.push_back(v(1,5,3,1,1,4,1,0,1,F,0,0,6));
    tbl.push_back(v(1,5,3,1,1,4,1,0,0,S,0,0,6));
    tbl.push_back(v(1,5,3,1,1,4,1,0,0,S,0,0,7));
    tbl.push_back(v(1,5,3,1,1,4,1,0,0,S,0,0,8));
    tbl.push_back(v(1,5,3,1,1,4,1,0,0,N,0,0,9));
    for (int i = 0; i < 3; i++) tbl.push_back(nop(0,0,9));
    tbl.push_back(v(1,1,2,1,1,7,1,0,0,N,0,0,9));
    tbl.push_back(v(1,8,7,1,0,10,1,0,0,N,0,0,9));
    for (int i = 0; i < 3; i++) tbl.push_back(nop(0,0,9));
    tbl.push_back(v(1,1,2,1,1,9,0,0,0,N,0,0,9));
    tbl.push_back(v(1,9,9,1,1,11,1,0,0,N,0,0,9));
    tbl.push_back(v(0,11,0,1,0,0,0,0,0,N,0,0,9));
    tbl.push_back(nop(0,0,9));
    tbl.push_back(nop(0,0,9));
    tbl.push_back(nop(0,0,9));
`endif

    reset = 1'b1;
    drive(nop(0,0,0));
    repeat (2) @(posedge clk);
    #1;
    check_all(-2, N, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check_all(-1, N, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      check_all(i, tbl[i].ctl, tbl[i].fa, tbl[i].fb, tbl[i].cnt);
    end

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge clk);
    drive(v(1,1,0,1,0,3,1,1,0,N,0,0,0));
    @(negedge clk);
    drive(v(1,5,3,1,1,4,1,0,0,N,0,0,0));
    #1;
    chk("pre_reset_stall", 100, stall_f, 1);
    chk("pre_reset_cnt_nonzero", 100, (stall_cnt != 0) ? 1 : 0, 1);
    reset = 1'b1;
    #1;
    check_all(101, N, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check_all(102, N, 0, 0, 0);
    @(negedge clk);
    drive(nop(0,0,0));
    #2;
    check_all(103, N, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. Tracks destination registers of the instructions in the execute, memory and writeback stages, detects read-after-write hazards against the instruction in decode, and drives fetch/decode stall, execute bubble insertion and execute-stage operand forwarding selects. Sits beside the decode/execute boundary and sequences the execute datapath; it owns no data words, only control.

## Interface
Parameters:
- STALL_CNT_W, 32, width of the saturating hazard-stall counter

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- id_valid  in  1  decode holds a real instruction
- id_rs, id_rt  in  5 each  source register numbers of decode instruction
- id_uses_rs, id_uses_rt  in  1 each  decode instruction reads rs / rt
- id_dst  in  5  destination register of decode instruction (rd or rt, already muxed)
- id_reg_write  in  1  decode instruction writes the register file
- id_mem_to_reg  in  1  decode instruction is a load
- mem_busy  in  1  memory stage not ready; freezes whole pipeline
- stall_f  out  1  hold PC
- stall_d  out  1  hold decode register
- flush_e  out  1  load bubble into execute register
- hold_e  out  1  hold execute register (freeze)
- fwd_a_sel, fwd_b_sel  out  2 each  execute operand source for rs / rt: 0 register file, 1 memory-stage ALU result, 2 writeback result
- stall_cnt  out  STALL_CNT_W  hazard-stall cycles since reset

## Operation
- Three-entry tracking pipeline ex, mem, wb; entry = {valid, dst, reg_write, mem_to_reg}.
- Advance (not frozen): ex <= (hazard or !id_valid) ? empty : decode entry; mem <= ex; wb <= mem.
- Freeze (mem_busy=1): all entries hold; stall_f=stall_d=hold_e=1, flush_e=0, forwarding selects hold; counter does not increment.
- An entry matches a source when valid, reg_write, dst==source, dst!=0, and the source is used. Register 0 never hazards or forwards.
- hazard (with forwarding): ex entry is a load matching rs or rt.
- On hazard and not frozen: stall_f=stall_d=flush_e=1, hold_e=0, stall_cnt increments (saturates at all-ones).
- Forwarding selects computed at advance for the instruction entering execute, registered: match against current ex entry (becomes mem) gives 1; else match against current mem entry (becomes wb) gives 2; else 0. Youngest wins. On bubble, selects = 0.
- Simultaneous hazard and mem_busy: freeze takes priority; hazard re-evaluated after release.

## Timing
- Reset values: all entries empty, stall_f=stall_d=flush_e=hold_e=0, fwd selects 0, stall_cnt 0.
- stall_f/stall_d/flush_e/hold_e are combinational from current state and decode inputs (same cycle).
- fwd_a_sel/fwd_b_sel valid the cycle the instruction occupies execute (one-cycle registered latency).
- Load-use stall lasts exactly one cycle with forwarding.
- Reset asserted mid-stall clears all state immediately; next cycle after release has no stall.

## Configuration
- HAZARD_FORWARD_EN defined: behaviour above.
- Undefined: fwd selects tied to 0; hazard = any of ex, mem, wb entries matches rs or rt (register file has no write-through), so a dependent instruction stalls up to 3 cycles; counter counts each.

## Structure
- Package pipes: hazard_entry_t struct, fwd_sel_t enum (FWD_RF, FWD_MEM, FWD_WB).
- Sub-module hazard_match: combinational entry-vs-source comparator (valid, reg_write, nonzero, equality, used), instantiated per entry/source pair.

## Test plan
- add $3,$1,$2 then add $4,$3,$5 -> no stall; fwd_a_sel=1 in second instruction's execute cycle.
- lw $3 then add $4,$5,$3 -> one cycle stall_f=stall_d=flush_e=1; then fwd_b_sel=2; stall_cnt=1.
- Writer to $0 then reader of $0 -> no stall, selects 0.
- mem_busy held 3 cycles during a load-use hazard -> hold_e=1 for 3 cycles, no flush, stall_cnt unchanged until release, then one stall cycle.
- HAZARD_FORWARD_EN undefined: add $3 then add $4,$3 -> 3 stall cycles, stall_cnt=3.
- Reset asserted during a stall cycle -> all outputs 0 asynchronously; tracking entries empty.
